// File: rtl/sprite_line_fetch.sv
// Sprite row prefetcher: on each line start, copies the covering sprite row from the RGB ROM into a
// 16-entry line buffer, then serves registered per-pixel colour/hit. Optional macro: SPRITE_TRANSPARENT_EN.
module sprite_line_fetch #(
   parameter int SPRITE_W = 16,
   parameter int SPRITE_H = 18,
   parameter int COORD_W  = 10,
   parameter int ADDR_W   = 9,
   parameter int TIMEOUT  = 4
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_line_start,
   input  logic [COORD_W-1:0] i_line_y,
   input  logic [COORD_W-1:0] i_sprite_x,
   input  logic [COORD_W-1:0] i_sprite_y,
   input  logic               i_active,
   input  logic [COORD_W-1:0] i_x,
   output logic               o_rom_read,
   output logic [ADDR_W-1:0]  o_rom_address,
   input  logic [23:0]        i_rom_rgb_data,
   input  logic               i_rom_valid,
   output logic [23:0]        o_rgb,
   output logic               o_hit,
   output logic               o_fetch_err
);

   localparam int COL_W = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
   localparam int ROW_W = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam int DIF_W = COORD_W + 1;
   localparam logic signed [DIF_W-1:0] H_LIM = DIF_W'(SPRITE_H);
   localparam logic signed [DIF_W-1:0] W_LIM = DIF_W'(SPRITE_W);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_DONE
   } state_t;

   state_t r_state;
   state_t w_state_next;

   logic [COORD_W-1:0] r_sprite_x;
   logic [ROW_W-1:0]   r_row;
   logic [COL_W-1:0]   r_col;
   logic [CNT_W-1:0]   r_wait_cnt;
   logic [23:0]        r_buf [SPRITE_W];

   logic signed [DIF_W-1:0] w_dy;
   logic signed [DIF_W-1:0] w_dx;
   logic                    w_row_hit;
   logic                    w_col_hit;
   logic                    w_timeout;
   logic                    w_adv;
   logic                    w_last_col;
   logic                    w_buf_valid;
   logic                    w_key;
   logic                    w_hit;
   logic [23:0]             w_pix;
   logic [ADDR_W-1:0]       w_addr;

   // Differences are taken one bit wider so a point left of / above the sprite goes negative instead of wrapping.
   assign w_dy      = $signed({1'b0, i_line_y}) - $signed({1'b0, i_sprite_y});
   assign w_row_hit = !w_dy[DIF_W-1] && (w_dy < H_LIM);

   assign w_timeout  = (r_state == S_WAIT) && !i_rom_valid && (r_wait_cnt == CNT_W'(TIMEOUT - 1));
   assign w_adv      = (r_state == S_WAIT) && (i_rom_valid || w_timeout);
   assign w_last_col = (r_col == COL_W'(SPRITE_W - 1));
   assign w_addr     = ADDR_W'(r_row) * ADDR_W'(SPRITE_W) + ADDR_W'(r_col);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // A line start overrides every state, which is what aborts an in-flight fetch.
   always_comb begin
      w_state_next = r_state;
      if (i_line_start) begin
         w_state_next = w_row_hit ? S_REQ : S_IDLE;
      end else begin
         case (r_state)
            S_REQ:   w_state_next = S_WAIT;
            S_WAIT:  if (w_adv) w_state_next = w_last_col ? S_DONE : S_REQ;
            default: w_state_next = r_state;
         endcase
      end
   end

   always_comb begin
      o_rom_read    = (r_state == S_REQ);
      o_rom_address = w_addr;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sprite_x  <= '0;
         r_row       <= '0;
         r_col       <= '0;
         r_wait_cnt  <= '0;
         o_fetch_err <= 1'b0;
      end else if (i_line_start) begin
         r_sprite_x <= i_sprite_x;
         r_wait_cnt <= '0;
         if (w_row_hit) begin
            r_row <= w_dy[ROW_W-1:0];
            r_col <= '0;
         end
      end else begin
         case (r_state)
            S_REQ: r_wait_cnt <= '0;
            S_WAIT: begin
               if (w_timeout) o_fetch_err <= 1'b1;
               if (w_adv) begin
                  if (!w_last_col) r_col <= r_col + COL_W'(1);
               end else begin
                  r_wait_cnt <= r_wait_cnt + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // A timed-out pixel is stored as black so the row still completes.
   always_ff @(posedge i_clk) begin
      if (!i_line_start && w_adv) begin
         r_buf[r_col] <= i_rom_valid ? i_rom_rgb_data : 24'h000000;
      end
   end

   assign w_buf_valid = (r_state == S_DONE);
   assign w_dx        = $signed({1'b0, i_x}) - $signed({1'b0, r_sprite_x});
   assign w_col_hit   = !w_dx[DIF_W-1] && (w_dx < W_LIM);
   assign w_pix       = r_buf[w_dx[COL_W-1:0]];

`ifdef SPRITE_TRANSPARENT_EN
   assign w_key = (w_pix == 24'hFF00FF);
`else
   assign w_key = 1'b0;
`endif

   assign w_hit = i_active && w_buf_valid && w_col_hit && !w_key;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_hit <= 1'b0;
         o_rgb <= '0;
      end else begin
         o_hit <= w_hit;
         o_rgb <= w_hit ? w_pix : 24'h000000;
      end
   end

endmodule
